// File: rtl/lsu_wb_pkg.sv
// Shared encodings for the load/store writeback unit: FSM states, writeback select, access size.
package lsu_wb_pkg;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_WB   = 2'd3;

   // Writeback source select; value 3 is reserved and writes zero
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // Access size encodings
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

endpackage

// File: rtl/lsu_wb_unit_if.sv
// EXU handshake, memory request/response bus and GPR write port of the load/store writeback unit.
interface lsu_wb_unit_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) ();

   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_result;
   logic [XLEN-1:0]   in_pc;
   logic [RA_W-1:0]   in_rd;
   logic              in_reg_we;
   logic [1:0]        in_wb_sel;
   logic              in_mem_wr;
   logic [1:0]        in_size;
   logic              in_unsigned;
   logic [XLEN-1:0]   in_store_data;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_we;
   logic [XLEN-1:0]   mem_req_addr;
   logic [XLEN-1:0]   mem_req_wdata;
   logic [XLEN/8-1:0] mem_req_wstrb;
   logic              mem_resp_valid;
   logic [XLEN-1:0]   mem_resp_rdata;

   logic              wb_en;
   logic [RA_W-1:0]   wb_addr;
   logic [XLEN-1:0]   wb_data;
   logic              commit;
   logic              misalign;

   // Environment side: EXU plus memory plus GPR file
   modport master (
      output in_valid, in_result, in_pc, in_rd, in_reg_we, in_wb_sel, in_mem_wr, in_size,
             in_unsigned, in_store_data, mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input  in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
             wb_en, wb_addr, wb_data, commit, misalign
   );

   // Unit side
   modport slave (
      input  in_valid, in_result, in_pc, in_rd, in_reg_we, in_wb_sel, in_mem_wr, in_size,
             in_unsigned, in_store_data, mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output in_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
             wb_en, wb_addr, wb_data, commit, misalign
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store shift, strobe generation, load extract/extend and misalign detect.
module lsu_lane_align
   import lsu_wb_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]                  i_chk_off,
   input  logic [1:0]                  i_chk_size,
   output logic                        o_misalign,
   input  logic [$clog2(XLEN/8)-1:0]   i_off,
   input  logic [1:0]                  i_size,
   input  logic                        i_unsigned,
   input  logic [XLEN-1:0]             i_store_data,
   input  logic [XLEN-1:0]             i_rdata,
   output logic [XLEN-1:0]             o_wdata,
   output logic [XLEN/8-1:0]           o_wstrb,
   output logic [XLEN-1:0]             o_load_data
);

   logic [XLEN/8-1:0] w_mask;
   logic [XLEN-1:0]   w_shift;
   logic [XLEN-1:0]   w_word;
   logic              w_sx;

   assign o_wdata = i_store_data << {i_off, 3'b000};
   assign o_wstrb = w_mask << i_off;
   assign w_shift = i_rdata >> {i_off, 3'b000};
   assign w_sx    = ~i_unsigned;

   // Word loads only need extension when the register is wider than a word
   if (XLEN == 64) begin : g_word64
      assign w_word = {{(XLEN-32){w_sx & w_shift[31]}}, w_shift[31:0]};
   end else begin : g_word32
      assign w_word = w_shift;
   end

   // Natural-alignment check; dword accesses cannot be served on a 32-bit bus
   always_comb begin
      o_misalign = 1'b0;
      unique case (i_chk_size)
         SIZE_B: o_misalign = 1'b0;
         SIZE_H: o_misalign = i_chk_off[0];
         SIZE_W: o_misalign = (i_chk_off[1:0] != 2'b00);
         SIZE_D: o_misalign = (XLEN == 32) || (i_chk_off != 3'b000);
      endcase
   end

   // Unshifted byte-enable mask per access size
   always_comb begin
      w_mask = '0;
      unique case (i_size)
         SIZE_B: w_mask = (XLEN/8)'(8'h01);
         SIZE_H: w_mask = (XLEN/8)'(8'h03);
         SIZE_W: w_mask = (XLEN/8)'(8'h0F);
         SIZE_D: w_mask = '1;
      endcase
   end

   // Load data truncation and sign/zero extension
   always_comb begin
      o_load_data = '0;
      unique case (i_size)
         SIZE_B: o_load_data = {{(XLEN-8){w_sx & w_shift[7]}}, w_shift[7:0]};
         SIZE_H: o_load_data = {{(XLEN-16){w_sx & w_shift[15]}}, w_shift[15:0]};
         SIZE_W: o_load_data = w_word;
         SIZE_D: o_load_data = w_shift;
      endcase
   end

endmodule

// File: rtl/lsu_wb_unit.sv
// Multi-cycle load/store and writeback stage between EXU and the GPR file.
module lsu_wb_unit
   import lsu_wb_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   lsu_wb_unit_if.slave io
);

   localparam int unsigned OFF_W = $clog2(XLEN/8);

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [XLEN-1:0]   r_result;
   logic [XLEN-1:0]   r_pc;
   logic [RA_W-1:0]   r_rd;
   logic              r_reg_we;
   logic [1:0]        r_wb_sel;
   logic              r_mem_wr;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [XLEN-1:0]   r_store_data;
   logic [XLEN-1:0]   r_rdata;
   logic              r_err;

   logic              w_accept;
   logic              w_is_mem;
   logic              w_misalign;
   logic [XLEN-1:0]   w_wdata;
   logic [XLEN/8-1:0] w_wstrb;
   logic [XLEN-1:0]   w_load_data;

   assign io.in_ready = !rst && (r_state == ST_IDLE);
   assign w_accept    = io.in_valid && io.in_ready;
   assign w_is_mem    = (io.in_wb_sel == WB_MEM) || io.in_mem_wr;

   // Alignment is judged on the incoming instruction, lane steering on the captured one
   lsu_lane_align #(
      .XLEN (XLEN)
   ) u_align (
      .i_chk_off    (io.in_result[2:0]),
      .i_chk_size   (io.in_size),
      .o_misalign   (w_misalign),
      .i_off        (r_result[OFF_W-1:0]),
      .i_size       (r_size),
      .i_unsigned   (r_unsigned),
      .i_store_data (r_store_data),
      .i_rdata      (r_rdata),
      .o_wdata      (w_wdata),
      .o_wstrb      (w_wstrb),
      .o_load_data  (w_load_data)
   );

   // Next-state logic; misaligned accesses skip the bus and retire with the error flag
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE: if (w_accept) w_state_next = (w_is_mem && !w_misalign) ? ST_REQ : ST_WB;
         ST_REQ:  if (io.mem_req_ready) w_state_next = ST_WAIT;
         ST_WAIT: if (io.mem_resp_valid) w_state_next = ST_WB;
         ST_WB:   w_state_next = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Instruction capture on accept and load data capture on the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result     <= '0;
         r_pc         <= '0;
         r_rd         <= '0;
         r_reg_we     <= 1'b0;
         r_wb_sel     <= WB_ALU;
         r_mem_wr     <= 1'b0;
         r_size       <= SIZE_B;
         r_unsigned   <= 1'b0;
         r_store_data <= '0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
      end else begin
         if (w_accept) begin
            r_result     <= io.in_result;
            r_pc         <= io.in_pc;
            r_rd         <= io.in_rd;
            r_reg_we     <= io.in_reg_we;
            r_wb_sel     <= io.in_wb_sel;
            r_mem_wr     <= io.in_mem_wr;
            r_size       <= io.in_size;
            r_unsigned   <= io.in_unsigned;
            r_store_data <= io.in_store_data;
            r_err        <= w_is_mem && w_misalign;
         end
         if ((r_state == ST_WAIT) && io.mem_resp_valid && !r_mem_wr) begin
            r_rdata <= io.mem_resp_rdata;
         end
      end
   end

   // Memory request fields are held in registers, so they stay stable under backpressure
   assign io.mem_req_valid = (r_state == ST_REQ);
   assign io.mem_req_we    = r_mem_wr;
   assign io.mem_req_addr  = r_result;
   assign io.mem_req_wdata = w_wdata;
   assign io.mem_req_wstrb = (r_state == ST_REQ) ? w_wstrb : '0;

   // Writeback data select
   always_comb begin
      io.wb_data = '0;
      unique case (r_wb_sel)
         WB_ALU:  io.wb_data = r_result;
         WB_MEM:  io.wb_data = w_load_data;
         WB_PC4:  io.wb_data = r_pc + XLEN'(4);
         default: io.wb_data = '0;
      endcase
   end

   assign io.commit   = (r_state == ST_WB);
   assign io.misalign = (r_state == ST_WB) && r_err;
   assign io.wb_addr  = r_rd;
   assign io.wb_en    = (r_state == ST_WB) && r_reg_we && (r_rd != '0) && !r_err && !r_mem_wr;

endmodule

// File: tb/tb_lsu_wb_unit.sv
// Self-checking bench for lsu_wb_unit: vector table with a writeback scoreboard plus
// hand-written backpressure and reset-in-flight sequences.
`timescale 1ns/1ps
module tb_lsu_wb_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_wb_unit_if #(.XLEN(32), .RA_W(5)) bus ();

   lsu_wb_unit #(
      .XLEN (32),
      .RA_W (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   typedef struct {
      logic [1:0]  wb_sel;
      logic        mem_wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] result;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        reg_we;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic        req;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        en;
      logic [31:0] data;
      logic        mis;
   } vec_t;

   typedef struct {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[17];
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_commits = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Writeback monitor: every commit pops one expected retirement
   always @(negedge clk) begin
      if (!rst && bus.commit) begin
         n_commits++;
         if (sb_q.size() == 0) begin
            chk("unexpected_commit", 32'd1, 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("wb_en", {31'd0, bus.wb_en}, {31'd0, mon_e.en});
            chk("misalign", {31'd0, bus.misalign}, {31'd0, mon_e.mis});
            if (mon_e.en) begin
               chk("wb_addr", {27'd0, bus.wb_addr}, {27'd0, mon_e.addr});
               chk("wb_data", bus.wb_data, mon_e.data);
            end
         end
      end
      if (!rst && bus.wb_en && !bus.commit) chk("wb_en_outside_commit", 32'd1, 32'd0);
   end

   // Waits for in_ready, presents one instruction and returns at the negedge after accept
   task automatic drive_accept(input vec_t v);
      int n = 0;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
      bus.in_wb_sel     = v.wb_sel;
      bus.in_mem_wr     = v.mem_wr;
      bus.in_size       = v.size;
      bus.in_unsigned   = v.uns;
      bus.in_result     = v.result;
      bus.in_pc         = v.pc;
      bus.in_rd         = v.rd;
      bus.in_reg_we     = v.reg_we;
      bus.in_store_data = v.sdata;
      bus.in_valid      = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic push_exp(input vec_t v);
      exp_t e;
      e.en   = v.en;
      e.addr = v.rd;
      e.data = v.data;
      e.mis  = v.mis;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drain", sb_q.size(), 32'd0);
      sb_q.delete();
   endtask

   // One table entry with an immediately ready memory answering in the first WAIT cycle
   task automatic apply(input vec_t v);
      push_exp(v);
      drive_accept(v);
      chk("req_valid", {31'd0, bus.mem_req_valid}, {31'd0, v.req});
      if (v.req) begin
         chk("req_we", {31'd0, bus.mem_req_we}, {31'd0, v.mem_wr});
         chk("req_addr", bus.mem_req_addr, v.result);
         chk("req_wstrb", {28'd0, bus.mem_req_wstrb}, {28'd0, v.wstrb});
         if (v.mem_wr) chk("req_wdata", bus.mem_req_wdata, v.wdata);
         @(negedge clk);
         chk("wait_no_commit", {31'd0, bus.commit}, 32'd0);
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_rdata = v.rdata;
         @(negedge clk);
         bus.mem_resp_valid = 1'b0;
      end
      chk("commit_latency", {31'd0, bus.commit}, 32'd1);
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   c0;

      //           sel  wr   sz   uns  result        pc            rd     we
      //           sdata         rdata         req  wstrb    wdata         en   data         mis
      vecs[0]  = '{2'd0, 1'b0, 2'd0, 1'b0, 32'h1234_5678, 32'h8000_0000, 5'd5, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h1234_5678, 1'b0};
      vecs[1]  = '{2'd1, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h8000_0004, 5'd7, 1'b1,
                   32'h0, 32'h80FF_FFFF, 1'b1, 4'b1000, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0};
      vecs[2]  = '{2'd1, 1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h8000_0004, 5'd7, 1'b1,
                   32'h0, 32'h80FF_FFFF, 1'b1, 4'b1000, 32'h0, 1'b1, 32'h0000_0080, 1'b0};
      vecs[3]  = '{2'd0, 1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h8000_0008, 5'd3, 1'b1,
                   32'hABCD_1234, 32'h0, 1'b1, 4'b1100, 32'h1234_0000, 1'b0, 32'h0, 1'b0};
      vecs[4]  = '{2'd1, 1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h8000_000C, 5'd8, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[5]  = '{2'd2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8000_0FFC, 5'd0, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
      vecs[6]  = '{2'd2, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8000_0FFC, 5'd1, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h8000_1000, 1'b0};
      vecs[7]  = '{2'd1, 1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 5'd10, 1'b1,
                   32'h0, 32'h8001_0000, 1'b1, 4'b1100, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0};
      vecs[8]  = '{2'd1, 1'b0, 2'd1, 1'b1, 32'h8000_0000, 32'h0, 5'd11, 1'b1,
                   32'h0, 32'h1234_F00F, 1'b1, 4'b0011, 32'h0, 1'b1, 32'h0000_F00F, 1'b0};
      vecs[9]  = '{2'd1, 1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 5'd12, 1'b1,
                   32'h0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[10] = '{2'd0, 1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 5'd0, 1'b0,
                   32'hCAFE_F00D, 32'h0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
      vecs[11] = '{2'd0, 1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 5'd0, 1'b0,
                   32'h0000_00A5, 32'h0, 1'b1, 4'b0010, 32'h0000_A500, 1'b0, 32'h0, 1'b0};
      vecs[12] = '{2'd0, 1'b1, 2'd1, 1'b0, 32'h8000_0003, 32'h0, 5'd0, 1'b0,
                   32'h0000_0001, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[13] = '{2'd3, 1'b0, 2'd0, 1'b0, 32'h0000_0055, 32'h0, 5'd13, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, 1'b0};
      vecs[14] = '{2'd1, 1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 5'd14, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[15] = '{2'd0, 1'b0, 2'd0, 1'b0, 32'h0000_0077, 32'h0, 5'd0, 1'b1,
                   32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0};
      vecs[16] = '{2'd1, 1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 5'd15, 1'b1,
                   32'h0, 32'h0000_7F00, 1'b1, 4'b0010, 32'h0, 1'b1, 32'h0000_007F, 1'b0};

      rst                = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_result      = '0;
      bus.in_pc          = '0;
      bus.in_rd          = '0;
      bus.in_reg_we      = 1'b0;
      bus.in_wb_sel      = '0;
      bus.in_mem_wr      = 1'b0;
      bus.in_size        = '0;
      bus.in_unsigned    = 1'b0;
      bus.in_store_data  = '0;
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("rst_wstrb", {28'd0, bus.mem_req_wstrb}, 32'd0);
      chk("rst_commit", {31'd0, bus.commit}, 32'd0);
      chk("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

      for (int i = 0; i < 17; i++) apply(vecs[i]);

      // Backpressure: request held 5 cycles, stray responses during REQ ignored,
      // then a 3-cycle response delay in WAIT
      v = '{2'd1, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 5'd9, 1'b1,
            32'h0, 32'h1122_3344, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h1122_3344, 1'b0};
      c0 = n_commits;
      bus.mem_req_ready = 1'b0;
      push_exp(v);
      drive_accept(v);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
         chk("bp_req_addr", bus.mem_req_addr, 32'h8000_0010);
         chk("bp_req_wstrb", {28'd0, bus.mem_req_wstrb}, 32'h0000_000F);
         chk("bp_req_we", {31'd0, bus.mem_req_we}, 32'd0);
         @(negedge clk);
      end
      bus.mem_req_ready  = 1'b1;
      bus.mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("bp_wait_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("bp_wait_no_commit", {31'd0, bus.commit}, 32'd0);
         @(negedge clk);
      end
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 32'h1122_3344;
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      chk("bp_commit", {31'd0, bus.commit}, 32'd1);
      drain();
      repeat (2) @(negedge clk);
      chk("bp_one_commit", n_commits - c0, 32'd1);

      // Reset while waiting for a response; the late response must not retire anything
      v = '{2'd1, 1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 5'd6, 1'b1,
            32'h0, 32'h0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0, 1'b0};
      c0 = n_commits;
      drive_accept(v);
      chk("rw_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rw_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rw_rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rw_idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rw_late_commit", {31'd0, bus.commit}, 32'd0);
         chk("rw_late_wb_en", {31'd0, bus.wb_en}, 32'd0);
      end
      bus.mem_resp_valid = 1'b0;
      chk("rw_no_commit", n_commits - c0, 32'd0);

      // Unit still operates normally after the mid-flight reset
      apply(vecs[0]);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_wb_unit.md
# lsu_wb_unit

Multi-cycle load/store and writeback stage for the NPC core, placed between EXU and the GPR file. It accepts one instruction per handshake and selects writeback data from ALU result, memory load, or PC+4. Memory traffic goes through a registered request/response bus with byte strobes, replacing the combinational DPI access of the single-cycle writeback. Widths are parametrised, sub-word loads are sign- or zero-extended, and misaligned accesses are flagged.

## Interface
- XLEN, 32, data/address width; legal values 32 or 64
- RA_W, 5, register-address width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EXU holds a valid instruction
- in_ready  out  1  unit can accept; `!rst && state==IDLE`
- in_result  in  XLEN  ALU result / effective address
- in_pc  in  XLEN  instruction PC
- in_rd  in  RA_W  destination register
- in_reg_we  in  1  instruction writes rd
- in_wb_sel  in  2  0 ALU, 1 load data, 2 PC+4, 3 reserved (writes 0)
- in_mem_wr  in  1  store
- in_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only)
- in_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
- in_store_data  in  XLEN  rs2 value
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  write request
- mem_req_addr  out  XLEN  byte address (unaligned bits kept)
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wstrb  out  XLEN/8  byte-lane strobes
- mem_resp_valid  in  1  read data / write ack
- mem_resp_rdata  in  XLEN  full-lane read data
- wb_en, wb_addr, wb_data  out  1/RA_W/XLEN  GPR write port
- commit  out  1  one-cycle pulse per retired instruction
- misalign  out  1  one-cycle pulse with commit on a rejected access

## Operation
- FSM states: IDLE, REQ, WAIT, WB. All inputs are captured into registers on the accept edge (`in_valid && in_ready`).
- Accept transitions:
  - non-memory (`wb_sel!=1 && !mem_wr`) → WB.
  - memory, aligned → REQ.
  - memory, misaligned → WB with error flag set.
- Misalignment is `size==1 && a[0]`, `size==2 && a[1:0]!=0`, `size==3 && a[2:0]!=0`. `size==3` with XLEN=32 is also misaligned.
- REQ: `mem_req_valid=1`. Fields stay stable until `mem_req_ready`, then → WAIT.
- WAIT: on `mem_resp_valid`, latch `rdata` (loads only) → WB. A store treats `resp_valid` as its write ack.
- WB: for one cycle, `commit=1` and `wb_en = reg_we && rd!=0 && !err`; `misalign=err`. Then → IDLE.
- Data path (lane offset `o = a[log2(XLEN/8)-1:0]`):
  - Store data: `wdata = store_data << 8*o`.
  - Strobe: `wstrb = ((1<<(1<<size))-1) << o`.
  - Load data: `r = rdata >> 8*o`, truncated to `8<<size` bits, then sign- or zero-extended per `in_unsigned`. A word or dword equal to XLEN is passed through unchanged.
- `wb_data`: ALU → result; load → extended data; PC+4 → `pc+4` mod 2^XLEN.
- Stores never assert `wb_en`.

## Timing
- Reset values: state IDLE, all registered outputs 0. `in_ready=0` while rst is high.
- Reset mid-operation: return to IDLE immediately and drop `mem_req_valid`. A late `mem_resp_valid` is ignored (it is sampled only in WAIT).
- Latency:
  - non-memory: accepted at edge k, `wb_en` high in cycle k+1.
  - memory, with `req_ready=1` and the response arriving in the first WAIT cycle: REQ in k+1, WAIT in k+2, WB in k+3.
- `mem_resp_valid` during IDLE, REQ or WB is ignored.
- There is no accept in WB. The next accept happens in IDLE, so throughput is one instruction per 2 cycles minimum.
- Backpressure: `req_ready` held low keeps the unit in REQ indefinitely, with outputs stable.

## Structure
- Package `lsu_wb_pkg`:
  - state enum.
  - WB_ALU/WB_MEM/WB_PC4 constants.
  - SIZE_B/H/W/D encodings.
- Sub-module `lsu_lane_align` (purely combinational, parametrised by XLEN) contains the store shift, strobe generation, load extract/extend and misalign detect.

## Test plan
- ALU op: `result=0x1234_5678`, rd=5, wb_sel=0 → cycle k+1: `wb_en=1`, `wb_addr=5`, `wb_data=0x12345678`, `commit=1`.
- lb at addr 0x8000_0003, `rdata=0x80FF_FFFF`, signed → `wb_data=0xFFFF_FF80`. The same access as lbu → `0x0000_0080`.
- sh at 0x8000_0002, `store_data=0xABCD_1234` → `wstrb=4'b1100`, `wdata=0x1234_xxxx` (upper half 0x1234), `wb_en=0`.
- lw at 0x8000_0001 → no `mem_req_valid`, WB cycle with `misalign=1`, `wb_en=0`.
- `req_ready` held low 5 cycles, then a 3-cycle response delay → request fields stable throughout; one commit. Reset asserted in WAIT → next cycle IDLE; a late `resp_valid` produces no `wb_en`.
- jal with rd=0, `pc=0x8000_0FFC`, wb_sel=2 → `commit=1`, `wb_en=0`. With rd=1 → `wb_data=0x8000_1000`.
